// File: rtl/dmem_access_controller_if.sv
// dmem_access_controller_if: request/response handshake between the MEM stage and the data-memory controller.
interface dmem_access_controller_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  modport master (output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
                  input req_ready, resp_valid, resp_rdata, resp_err);
  modport slave (input req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
                 output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/dmem_access_controller.sv
// dmem_access_controller: one-at-a-time load/store sequencer for a 4-lane byte memory; SB/SH use read-modify-write.
module dmem_access_controller #(parameter int XLEN = 32) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_access_controller_if.slave bus,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic [XLEN-1:0]       mem_read_addr,
  output logic [XLEN-1:0]       mem_write_addr,
  output logic [3:0][7:0]       mem_write_data,
  input  logic [3:0][7:0]       mem_read_data
);
  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, ERR, RESP} state_t;
  state_t state, state_nx;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q, base, load_val;
  logic            err_q, accept, req_err;
  logic [3:0][7:0] merge_q, merged;
  logic [1:0]      off, off1, in_off;
  logic [7:0]      lb;
  logic [15:0]     lh;
  assign accept = bus.req_valid && bus.req_ready;
  assign in_off = bus.req_addr[1:0];
  // funct3[1:0]==11 is illegal for loads (011/111); stores only allow 000..010
  assign req_err = (bus.req_write ? bus.req_funct3 > 3'd2
                                  : (bus.req_funct3 == 3'd3 || bus.req_funct3[2:1] == 2'b11))
                 || (bus.req_funct3[1:0] == 2'b01 && in_off[0])
                 || (bus.req_funct3[1:0] == 2'b10 && in_off != 2'd0);
  assign off  = addr_q[1:0];
  assign off1 = off + 2'd1;
  assign base = {addr_q[XLEN-1:2], 2'b00};
  assign lb   = mem_read_data[off];
  assign lh   = {mem_read_data[off1], mem_read_data[off]};
  assign load_val = funct3_q[1:0] == 2'b00 ? {{(XLEN-8){lb[7] & ~funct3_q[2]}}, lb}
                  : funct3_q[1:0] == 2'b01 ? {{(XLEN-16){lh[15] & ~funct3_q[2]}}, lh}
                  : XLEN'(mem_read_data);
  always_comb begin
    merged      = merge_q;
    merged[off] = wdata_q[7:0];
    if (funct3_q[0]) merged[off1] = wdata_q[15:8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:               if (accept) state_nx = req_err ? ERR : !bus.req_write ? RD : bus.req_funct3 == 3'd2 ? WR : RMW_RD;
      RD, WR, RMW_WR, ERR: state_nx = RESP;
      RMW_RD:             state_nx = RMW_WR;
      RESP:               if (bus.resp_ready) state_nx = IDLE;
      default:            state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready    = state == IDLE;
    bus.resp_valid   = state == RESP;
    bus.resp_rdata   = rdata_q;
    bus.resp_err     = err_q;
    mem_read_enable  = state == RD || state == RMW_RD;
    mem_write_enable = state == WR || state == RMW_WR;
    mem_read_addr    = mem_read_enable ? base : '0;
    mem_write_addr   = mem_write_enable ? base : '0;
    mem_write_data   = state == WR ? 32'(wdata_q) : state == RMW_WR ? merged : '0;
  end
  // rdata/err cleared at accept so stores and errors respond with zero data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      merge_q  <= '0;
    end else begin
      if (accept) begin
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        rdata_q  <= '0;
        err_q    <= 1'b0;
      end
      if (state == RD) rdata_q <= load_val;
      if (state == RMW_RD) merge_q <= mem_read_data;
      if (state == ERR) err_q <= 1'b1;
      if (state == RESP && bus.resp_ready) err_q <= 1'b0;
    end
endmodule

// File: tb/tb_dmem_access_controller.sv
// tb_dmem_access_controller: directed and random load/store traffic checked against a byte-array reference model.
module tb_dmem_access_controller;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  dmem_access_controller_if #(.XLEN(32)) ifc();
  logic mre, mwe;
  logic [31:0] mra, mwa;
  logic [3:0][7:0] mwd, mrd;
  dmem_access_controller #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc),
    .mem_read_enable(mre), .mem_write_enable(mwe),
    .mem_read_addr(mra), .mem_write_addr(mwa),
    .mem_write_data(mwd), .mem_read_data(mrd));
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  assign mrd = {mem[{mra[7:2], 2'd3}], mem[{mra[7:2], 2'd2}], mem[{mra[7:2], 2'd1}], mem[{mra[7:2], 2'd0}]};
  always @(posedge clk) if (mwe) for (int i = 0; i < 4; i++) mem[{mwa[7:2], 2'(i)}] <= mwd[i];
  int tests = 0, fails = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: expected response, memory traffic and lane contents per accepted request
  logic busy = 1'b0, exp_err = 1'b0, st_pend = 1'b0;
  int cyc = 0, exp_lat = 0, exp_nr = 0, exp_nw = 0, nr = 0, nw = 0;
  logic [31:0] exp_rd = 0, exp_base = 0, exp_word = 0;
  initial begin
    logic acc, hs, legal, w;
    logic [31:0] v, a, d;
    logic [2:0] f;
    logic [1:0] o;
    int sz;
    forever begin
      @(posedge clk);
      acc = rst_n && ifc.req_valid && ifc.req_ready;
      hs  = rst_n && busy && ifc.resp_valid && ifc.resp_ready;
      if (busy) cyc++;
      if (hs) begin
        check("reads per op", nr, exp_nr);
        check("writes per op", nw, exp_nw);
        if (st_pend) for (int j = 0; j < 4; j++) ref_mem[{exp_base[7:2], 2'(j)}] = exp_word[8*j+:8];
        busy = 1'b0;
      end
      if (acc) begin
        a = ifc.req_addr; d = ifc.req_wdata; f = ifc.req_funct3; w = ifc.req_write; o = a[1:0];
        sz = 1 << f[1:0];
        legal = w ? f <= 3'd2 : (f != 3'd3 && f < 3'd6);
        exp_err = !legal || (a % sz != 0);
        exp_base = a & ~32'd3;
        exp_lat = 2; exp_nr = 0; exp_nw = 0; exp_rd = 0; st_pend = 1'b0; exp_word = 0;
        if (!exp_err && !w) begin
          v = 0;
          for (int i = 0; i < sz; i++) v |= 32'(ref_mem[8'(a[7:0] + 8'(i))]) << (8 * i);
          if (!f[2] && sz < 4 && v[8*sz-1]) v |= 32'hFFFF_FFFF << (8 * sz);
          exp_rd = v; exp_nr = 1;
        end
        if (!exp_err && w) begin
          exp_nw = 1; exp_nr = sz < 4 ? 1 : 0; exp_lat = sz < 4 ? 3 : 2; st_pend = 1'b1;
          for (int j = 0; j < 4; j++)
            exp_word[8*j+:8] = (j >= int'(o) && j < int'(o) + sz) ? 8'(d >> (8 * (j - int'(o)))) : ref_mem[{a[7:2], 2'(j)}];
        end
        busy = 1'b1; cyc = 1; nr = 0; nw = 0;
      end
      @(negedge clk);
      if (!rst_n) busy = 1'b0;
      else begin
        check("req_ready", 32'(ifc.req_ready), 32'(!busy));
        check("resp_valid", 32'(ifc.resp_valid), 32'(busy && cyc >= exp_lat));
        if (ifc.resp_valid) begin
          check("resp_rdata", ifc.resp_rdata, exp_rd);
          check("resp_err", 32'(ifc.resp_err), 32'(exp_err));
        end
        check("rd/wr exclusive", 32'(mre & mwe), 0);
        if (mre) begin nr++; check("read addr", mra, exp_base); end
        if (mwe) begin nw++; check("write addr", mwa, exp_base); check("write data", mwd, exp_word); end
        if (!busy || cyc >= exp_lat) check("mem quiet", 32'({mre, mwe}), 0);
        if (!mre && !mwe) check("mem bus zero", mra | mwa | mwd, 0);
      end
    end
  end
  task automatic txn(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                     input int hold, output logic [31:0] rd, output logic e, output int lat);
    int n;
    @(negedge clk);
    ifc.req_valid = 1'b1; ifc.req_write = w; ifc.req_funct3 = f; ifc.req_addr = a; ifc.req_wdata = d;
    n = 0;
    while (!ifc.req_ready && n < 50) begin @(negedge clk); n++; end
    if (n == 50) check("accept timeout", 0, 1);
    @(posedge clk); #1 ifc.req_valid = 1'b0;
    lat = 1;
    while (!ifc.resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = ifc.resp_rdata; e = ifc.resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold rdata", ifc.resp_rdata, rd);
      check("hold valid", 32'(ifc.resp_valid), 1);
      check("hold req_ready", 32'(ifc.req_ready), 0);
    end
    @(negedge clk); ifc.resp_ready = 1'b1;
    @(posedge clk); #1 ifc.resp_ready = 1'b0;
    check("ready after handshake", 32'(ifc.req_ready), 1);
  endtask
  logic [2:0] load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] err_f3 [4] = '{3'd1, 3'd2, 3'd2, 3'd3};
  logic [31:0] err_addr [4] = '{32'h101, 32'h102, 32'h103, 32'h100};
  logic err_w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  initial begin
    logic [31:0] rd, a;
    logic e, w;
    logic [2:0] f;
    int lat;
    ifc.req_valid = 0; ifc.req_write = 0; ifc.req_funct3 = 0; ifc.req_addr = 0; ifc.req_wdata = 0; ifc.resp_ready = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset req_ready", 32'(ifc.req_ready), 1);
    check("reset resp", 32'({ifc.resp_valid, ifc.resp_err}), 0);
    check("reset rdata", ifc.resp_rdata, 0);
    check("reset mem enables", 32'({mre, mwe}), 0);
    rst_n = 1'b1;
    txn(1, 3'd2, 32'h100, 32'h1122_3344, 0, rd, e, lat);
    // SB aborted by reset while in its write cycle
    @(negedge clk);
    ifc.req_valid = 1; ifc.req_write = 1; ifc.req_funct3 = 3'd0; ifc.req_addr = 32'h100; ifc.req_wdata = 32'h55;
    @(posedge clk); #1 ifc.req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("rmw write phase", 32'(mwe), 1);
    rst_n = 1'b0; #1;
    check("abort enables", 32'({mre, mwe}), 0);
    check("abort mem bus", mra | mwa | mwd, 0);
    check("abort resp", 32'({ifc.resp_valid, ifc.resp_err}), 0);
    check("abort rdata", ifc.resp_rdata, 0);
    check("abort req_ready", 32'(ifc.req_ready), 1);
    @(negedge clk); rst_n = 1'b1;
    check("no write after reset", {mem[3], mem[2], mem[1], mem[0]}, 32'h1122_3344);
    txn(1, 3'd2, 32'h100, 32'hDEAD_BEEF, 0, rd, e, lat);
    check("SW latency", lat, 2);
    check("SW lanes", {mem[3], mem[2], mem[1], mem[0]}, 32'hDEAD_BEEF);
    check("SW lane0", 32'(mem[0]), 32'hEF);
    txn(0, 3'd2, 32'h100, 0, 0, rd, e, lat);
    check("LW data", rd, 32'hDEAD_BEEF);
    check("LW err", 32'(e), 0);
    check("LW latency", lat, 2);
    txn(1, 3'd2, 32'h100, 32'h8011_2233, 0, rd, e, lat);
    txn(0, 3'd0, 32'h103, 0, 0, rd, e, lat);
    check("LB sign", rd, 32'hFFFF_FF80);
    txn(0, 3'd4, 32'h103, 0, 0, rd, e, lat);
    check("LBU zero", rd, 32'h0000_0080);
    txn(1, 3'd2, 32'h100, 32'h1122_3344, 0, rd, e, lat);
    txn(1, 3'd0, 32'h101, 32'h0000_00AA, 0, rd, e, lat);
    check("SB latency", lat, 3);
    check("SB rdata", rd, 0);
    txn(0, 3'd2, 32'h100, 0, 0, rd, e, lat);
    check("SB merge", rd, 32'h1122_AA44);
    txn(1, 3'd1, 32'h102, 32'h0000_BBCC, 0, rd, e, lat);
    check("SH latency", lat, 3);
    txn(0, 3'd2, 32'h100, 0, 0, rd, e, lat);
    check("SH merge", rd, 32'hBBCC_AA44);
    for (int i = 0; i < 4; i++) begin
      txn(err_w[i], err_f3[i], err_addr[i], 32'h1234_5678, 0, rd, e, lat);
      check("err flag", 32'(e), 1);
      check("err rdata", rd, 0);
      check("err latency", lat, 2);
    end
    check("err no write", {mem[3], mem[2], mem[1], mem[0]}, 32'hBBCC_AA44);
    txn(0, 3'd2, 32'h100, 0, 5, rd, e, lat);
    check("backpressure LW", rd, 32'hBBCC_AA44);
    for (int i = 0; i < 400; i++) begin
      w = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : w ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 4)];
      a = $urandom();
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(1 << f[1:0]) - 32'd1);
      txn(w, f, a, $urandom(), int'($urandom_range(0, 3)), rd, e, lat);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_access_controller.md
Name: dmem_access_controller

Overview:
- Sequences all core load/store traffic into the byte-lane data memory (4 x 8-bit lanes, combinational read, write on enable).
- Accepts one request at a time from the MEM stage, checks alignment and funct3, and issues the memory accesses.
- Stores narrower than a word (SB, SH) are done as read-modify-write.
- Returns sign- or zero-extended load data, or an error flag, through a valid/ready response.

Parameters:
- XLEN, 32, data and address width; the memory data bus is XLEN/8 byte lanes.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data (low bytes used for SB/SH)
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned address or illegal funct3
- mem_read_enable  out  1  to data memory
- mem_write_enable  out  1  to data memory
- mem_read_addr  out  XLEN  word-aligned address
- mem_write_addr  out  XLEN  word-aligned address
- mem_write_data  out  [3:0][7:0]  lane i = byte at address + i
- mem_read_data  in  [3:0][7:0]  combinational read result

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; req_ready = 1.
  - resp_valid, resp_err, resp_rdata, every mem_* output and every internal register = 0.
  - Reset asserted mid-operation aborts the operation immediately; no write is issued after reset asserts.
- Request handshake: a request is accepted on a rising edge where req_valid && req_ready. req_ready = 1 only in IDLE.
- On accept, the controller latches write, funct3, addr, wdata and computes:
  - base = {addr[XLEN-1:2], 2'b00}; off = addr[1:0].
  - err = illegal funct3 (loads 011/110/111; stores any code other than 000/001/010)
    OR (halfword && off[0]) OR (word && off != 0).
- States and transitions:
  - IDLE: accept request → ERR if err; else RD if load; else WR if SW; else RMW_RD.
  - RD: mem_read_enable = 1, mem_read_addr = base. Extract and extend at off:
    - LB/LBU: byte lane[off].
    - LH/LHU: lanes[off+1:off].
    - LW: all lanes.
    - Signed loads sign-extend; LBU/LHU zero-extend.
    - Register the result into resp_rdata → RESP.
  - WR: mem_write_enable = 1, mem_write_addr = base, mem_write_data = wdata → RESP.
  - RMW_RD: mem_read_enable = 1 at base; register mem_read_data into the merge buffer → RMW_WR.
  - RMW_WR: mem_write_enable = 1 at base; data = merge buffer with lane[off] replaced (SB), or lanes[off+1:off] replaced (SH), by the low bytes of wdata → RESP.
  - ERR: no memory enables. resp_err = 1, resp_rdata = 0 → RESP.
  - RESP: resp_valid = 1; resp_rdata and resp_err are held stable. On resp_valid && resp_ready → IDLE, clear resp_valid and resp_err.
- mem_* outputs are combinational from state and latched fields. They are 0 in every state not listed above. Read and write enables are never high in the same cycle.
- Latency, from the accept edge to resp_valid high:
  - load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - error: 2 cycles.
- Back-to-back: the earliest next accept is the cycle after the response handshake, since IDLE re-asserts req_ready. No request overlap.
- Address arithmetic wraps modulo 2^XLEN; base is never incremented, so no lane crosses a word boundary.
- Stalled response (resp_ready = 0): stay in RESP indefinitely; the memory sees no activity.

Test Plan:
- Reset mid-op: reset during RMW_WR of SB to 0x100 → no write occurs; all outputs 0; req_ready = 1 after release.
- SW then LW: SW 0x100 data 0xDEADBEEF, then LW 0x100 → write lanes {EF,BE,AD,DE}; resp_rdata = 0xDEADBEEF, resp_err = 0, each response 2 cycles after accept.
- Byte loads: with 0x80 in lane 3 of word 0x100:
  - LB 0x103 → 0xFFFFFF80.
  - LBU 0x103 → 0x00000080.
- Sub-word stores: memory word 0x100 = 0x11223344.
  - SB 0x101 wdata 0xAA → read, then write 0x1122AA44; resp after 3 cycles.
  - SH 0x102 wdata 0xBBCC → 0xBBCCAA44.
- Errors: LH 0x101, LW 0x102, SW 0x103, and load funct3 = 011 → resp_err = 1, resp_rdata = 0, memory enables never asserted.
- Backpressure: hold resp_ready = 0 for 5 cycles after an LW → resp_valid and resp_rdata stable, req_ready = 0; new request accepted the cycle after the handshake.
